// File: rtl/fac_bit.sv
// One-bit full adder: the ripple element chained inside fac_cell.
module fac_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic z,
  output logic co
);

  logic half;

  assign half = x ^ y;
  assign z    = half ^ ci;
  assign co   = (x & y) | (ci & half);

endmodule

// File: rtl/fac_cell.sv
// WIDTH-bit ripple-carry adder built from fac_bit, with an optional
// one-cycle output register stage carrying a valid flag.
module fac_cell #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] z,
  output logic             co,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumBits;

  assign carry[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : gRipple
    fac_bit uBit (
      .x  (x[i]),
      .y  (y[i]),
      .ci (carry[i]),
      .z  (sumBits[i]),
      .co (carry[i+1])
    );
  end

  if (REG_OUT) begin : gReg
    logic [WIDTH-1:0] z_q, z_d;
    logic             co_q, co_d;
    logic             valid_q;

    // Operands are captured only when qualified; otherwise the last result is held.
    always_comb begin
      z_d  = z_q;
      co_d = co_q;
      if (in_valid) begin
        z_d  = sumBits;
        co_d = carry[WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q     <= '0;
        co_q    <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        z_q     <= z_d;
        co_q    <= co_d;
        valid_q <= in_valid;
      end
    end

    assign z         = z_q;
    assign co        = co_q;
    assign out_valid = valid_q;
  end else begin : gComb
    logic unused_clkRst;

    // Clock and reset have no role in the purely combinational variant.
    assign unused_clkRst = clk ^ rst_n;
    assign z             = sumBits;
    assign co            = carry[WIDTH];
    assign out_valid     = in_valid;
  end

endmodule

// File: tb/tb_fac_cell.sv
// Self-checking bench for fac_cell: combinational and registered variants
// compared against plain x+y+ci arithmetic.
module tb_fac_cell;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid;
  logic       ci;
  logic       x1, y1;
  logic [1:0] x2, y2;
  logic [7:0] x8, y8;

  logic       z1c, co1c, v1c;
  logic       z1r, co1r, v1r;
  logic [1:0] z2c;
  logic       co2c, v2c;
  logic [7:0] z8r;
  logic       co8r, v8r;

  int nAssert = 0;
  int nFail   = 0;

  // Registered-output reference state.
  logic [1:0] exp1r;
  logic       expV1r;
  logic [8:0] exp8r;
  logic       expV8r;

  always #5 clk = ~clk;

  fac_cell #(.WIDTH(1), .REG_OUT(1'b0)) u1c (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x1), .y(y1), .ci(ci),
    .z(z1c), .co(co1c), .out_valid(v1c)
  );

  fac_cell #(.WIDTH(1), .REG_OUT(1'b1)) u1r (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x1), .y(y1), .ci(ci),
    .z(z1r), .co(co1r), .out_valid(v1r)
  );

  fac_cell #(.WIDTH(2), .REG_OUT(1'b0)) u2c (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x2), .y(y2), .ci(ci),
    .z(z2c), .co(co2c), .out_valid(v2c)
  );

  fac_cell #(.WIDTH(8), .REG_OUT(1'b1)) u8r (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x8), .y(y8), .ci(ci),
    .z(z8r), .co(co8r), .out_valid(v8r)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRegistered(input string tag);
    checkOutput({tag, "_w1reg"}, {13'd0, v1r, co1r, z1r}, {13'd0, expV1r, exp1r});
    checkOutput({tag, "_w8reg"}, {6'd0, v8r, co8r, z8r}, {6'd0, expV8r, exp8r});
  endtask

  // Drive one operand set, check the combinational instances, then clock it
  // through the reference model and check the registered instances.
  task automatic applyStimulus(input string tag, input logic v, input logic a1, input logic b1,
                               input logic [1:0] a2, input logic [1:0] b2,
                               input logic [7:0] a8, input logic [7:0] b8, input logic c);
    logic [1:0] e1;
    logic [2:0] e2;
    logic [8:0] e8;
    inValid = v; x1 = a1; y1 = b1; x2 = a2; y2 = b2; x8 = a8; y8 = b8; ci = c;
    e1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c};
    e2 = {1'b0, a2} + {1'b0, b2} + {2'b0, c};
    e8 = {1'b0, a8} + {1'b0, b8} + {8'b0, c};
    #1;
    checkOutput({tag, "_w1comb"}, {13'd0, v1c, co1c, z1c}, {13'd0, v, e1});
    checkOutput({tag, "_w2comb"}, {12'd0, v2c, co2c, z2c}, {12'd0, v, e2});
    @(posedge clk);
    if (v) begin
      exp1r = e1;
      exp8r = e8;
    end
    expV1r = v;
    expV8r = v;
    #1;
    checkRegistered(tag);
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; ci = 1'b0;
    x1 = 1'b0; y1 = 1'b0; x2 = '0; y2 = '0; x8 = '0; y8 = '0;
    exp1r = '0; expV1r = 1'b0; exp8r = '0; expV8r = 1'b0;
    #1;
    checkRegistered("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegistered("afterRelease");

    // Exhaustive 1-bit sweep on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] code;
      code = 3'(i);
      applyStimulus("sweep1", 1'b1, code[2], code[1], 2'b00, 2'b00, 8'd0, 8'd0, code[0]);
    end

    // Exhaustive 2-bit sweep.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] code;
      code = 5'(i);
      applyStimulus("sweep2", 1'b1, code[0], code[1], code[4:3], code[2:1], {3'd0, code}, 8'd0, code[0]);
    end
    applyStimulus("w2_3p3p1", 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 8'hFF, 8'hFF, 1'b1);
    applyStimulus("w2_2p1p0", 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 8'h80, 8'h7F, 1'b0);

    // Hold: previous result stays while in_valid is low.
    applyStimulus("holdLoad", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 8'h12, 8'h34, 1'b0);
    applyStimulus("holdIdle", 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 8'hAA, 8'h55, 1'b0);
    applyStimulus("holdIdle2", 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 8'h01, 8'h02, 1'b1);

    // Async reset between edges clears everything before the next edge.
    applyStimulus("preReset", 1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 8'hF0, 8'h0F, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp1r = '0; expV1r = 1'b0; exp8r = '0; expV8r = 1'b0;
    checkRegistered("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("postReset", 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 8'h01, 8'h01, 1'b0);

    // Randomized traffic with random qualification.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                    2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
